// File: rtl/switch_debounce_pkg.sv
// Shared constants and types for the 64-switch debouncer.
// Also holds the sizing helper for the per-bit agree counter.
package switch_debounce_pkg;

  localparam int NUM_SW = 64;

  typedef logic [NUM_SW-1:0] sw_vec_t;

  // Counter must hold values up to STABLE_CNT-1; sized for STABLE_CNT+1 to stay >= 1 bit.
  function automatic int agree_width(input int stable_cnt);
    return $clog2(stable_cnt + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One-switch debouncer: accepts a new level after STABLE_CNT consecutive
// disagreeing sample ticks, and produces registered rise/fall pulses.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  localparam int AW = agree_width(STABLE_CNT);
  localparam logic [AW-1:0] CNT_LAST = AW'(STABLE_CNT - 1);

  logic [AW-1:0] agree_reg, agree_next;
  logic          stable_reg, stable_next;
  logic          rise_reg, fall_reg;

  always_comb begin
    agree_next  = agree_reg;
    stable_next = stable_reg;
    if (tick) begin
      if (raw == stable_reg) begin
        agree_next = '0;
      end else if (agree_reg == CNT_LAST) begin
        stable_next = raw;
        agree_next  = '0;
      end else begin
        agree_next = agree_reg + 1'b1;
      end
    end
  end

  // Pulses are computed from the next level so they land with the new stable value.
  assign rise_next = stable_next & ~stable_reg;
  assign fall_next = ~stable_next & stable_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      agree_reg  <= '0;
      stable_reg <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
    end else begin
      agree_reg  <= agree_next;
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
    end
  end

  assign stable = stable_reg;
  assign rise   = rise_reg;
  assign fall   = fall_reg;

endmodule

// File: rtl/switch_debounce.sv
// Debounce, edge detect and sticky press capture for the 64-switch image
// coming from the serial shift driver.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_SW-1:0] data_in,
  output logic [NUM_SW-1:0] stable,
  output logic [NUM_SW-1:0] press,
  output logic [NUM_SW-1:0] release_pulse,
  output logic              any_change,
  output logic [NUM_SW-1:0] press_latched,
  input  logic              clr_en,
  input  logic [NUM_SW-1:0] clr_mask
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic             tick;

  assign tick     = (div_reg == DIV_LAST);
  assign div_next = tick ? '0 : div_reg + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  sw_vec_t press_next, release_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_CNT(STABLE_CNT)
      ) u_bit (
        .clk      (clk),
        .resetn   (resetn),
        .tick     (tick),
        .raw      (data_in[gi]),
        .stable   (stable[gi]),
        .rise     (press[gi]),
        .fall     (release_pulse[gi]),
        .rise_next(press_next[gi]),
        .fall_next(release_next[gi])
      );
    end
  endgenerate

  sw_vec_t press_latched_reg, press_latched_next;
  logic    any_change_reg, any_change_next;

  // OR-ing the new press after masking lets a set beat a same-cycle clear.
  assign press_latched_next = (press_latched_reg & ~(clr_en ? clr_mask : '0)) | press_next;
  assign any_change_next    = |(press_next | release_next);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      press_latched_reg <= '0;
      any_change_reg    <= 1'b0;
    end else begin
      press_latched_reg <= press_latched_next;
      any_change_reg    <= any_change_next;
    end
  end

  assign press_latched = press_latched_reg;
  assign any_change    = any_change_reg;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed checks of switch_debounce against a sliding-window
// reference: a level is accepted once the last STABLE_CNT samples all differ from it.
module tb_switch_debounce;

  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_CNT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] stable, press, release_pulse, press_latched;
  logic        any_change;
  logic        clr_en = 1'b0;
  logic [63:0] clr_mask = '0;

  always #5 clk = ~clk;

  switch_debounce #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in),
    .stable       (stable),
    .press        (press),
    .release_pulse(release_pulse),
    .any_change   (any_change),
    .press_latched(press_latched),
    .clr_en       (clr_en),
    .clr_mask     (clr_mask)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [63:0] m_win [STABLE_CNT];
  logic [63:0] m_stable, m_press, m_rel, m_latched;
  int          m_phase;
  int          cyc;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < STABLE_CNT; i++) m_win[i] = '0;
    m_stable  = '0;
    m_press   = '0;
    m_rel     = '0;
    m_latched = '0;
    m_phase   = 0;
  endtask

  task automatic check_all();
    chk_val("stable", stable, m_stable);
    chk_val("press", press, m_press);
    chk_val("release", release_pulse, m_rel);
    chk_val("any_change", {63'd0, any_change}, {63'd0, |(m_press | m_rel)});
    chk_val("press_latched", press_latched, m_latched);
  endtask

  task automatic step(input logic [63:0] d, input logic ce, input logic [63:0] cm);
    logic [63:0] diff_all, new_stable;
    data_in  = d;
    clr_en   = ce;
    clr_mask = cm;
    new_stable = m_stable;
    if (m_phase == SAMPLE_DIV - 1) begin
      for (int i = STABLE_CNT - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = d;
      diff_all = '1;
      for (int i = 0; i < STABLE_CNT; i++) diff_all &= (m_win[i] ^ m_stable);
      new_stable = m_stable ^ diff_all;
    end
    m_phase   = (m_phase + 1) % SAMPLE_DIV;
    m_press   = new_stable & ~m_stable;
    m_rel     = m_stable & ~new_stable;
    m_latched = (m_latched & ~(ce ? cm : 64'd0)) | m_press;
    m_stable  = new_stable;
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (|(m_press | m_rel))
      $display("cyc %0d: press=%h release=%h stable=%h", cyc, m_press, m_rel, m_stable);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    #1;
    chk_val("rst_stable", stable, 64'd0);
    chk_val("rst_press", press, 64'd0);
    chk_val("rst_release", release_pulse, 64'd0);
    chk_val("rst_any", {63'd0, any_change}, 64'd0);
    chk_val("rst_latched", press_latched, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    cyc = 0;
    $display("reset released");
  endtask

  task automatic align(input logic [63:0] d);
    while (m_phase != 0) step(d, 1'b0, '0);
  endtask

  logic [63:0] d, flips;

  initial begin
    model_reset();
    cyc = 0;
    #12;
    apply_reset();

    // Idle
    for (int i = 0; i < 100; i++) step('0, 1'b0, '0);
    $display("idle done");

    // Clean press on bits 0 and 16
    align('0);
    d = 64'h0000_0000_0001_0001;
    for (int i = 0; i < 16; i++) step(d, 1'b0, '0);
    chk_val("press0_latched", {63'd0, press_latched[0]}, 64'd1);

    // Glitch on bit 5 for two ticks
    align(d);
    for (int i = 0; i < 8; i++) step(d | 64'h20, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(d, 1'b0, '0);
    chk_val("glitch5_stable", {63'd0, stable[5]}, 64'd0);
    chk_val("glitch5_latched", {63'd0, press_latched[5]}, 64'd0);

    // Release bit 0
    d = 64'h0000_0000_0001_0000;
    for (int i = 0; i < 16; i++) step(d, 1'b0, '0);
    chk_val("rel0_latched", {63'd0, press_latched[0]}, 64'd1);

    // Clear bit 0, then a new press with clear held every cycle
    step(d, 1'b1, 64'h1);
    d = 64'h0000_0000_0001_0001;
    for (int i = 0; i < 16; i++) begin
      step(d, 1'b1, 64'h1);
      if (m_press[0]) chk_val("collision_latched0", {63'd0, press_latched[0]}, 64'd1);
    end
    step(d, 1'b1, 64'h1_0000);
    chk_val("clr16", {63'd0, press_latched[16]}, 64'd0);
    $display("clear checks done");

    // Async reset between ticks 2 and 3 of a pending change on bit 3
    align(d);
    for (int i = 0; i < 9; i++) step(d | 64'h8, 1'b0, '0);
    #1;
    apply_reset();
    for (int i = 0; i < 11; i++) step(64'h8, 1'b0, '0);
    chk_val("postrst_pending3", {63'd0, stable[3]}, 64'd0);
    step(64'h8, 1'b0, '0);
    chk_val("postrst_done3", {63'd0, stable[3]}, 64'd1);

    // Random slowly-changing switches with random clears
    d = 64'h8;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        d ^= flips;
      end
      if ($urandom_range(0, 15) == 0)
        step(d, 1'b1, {$urandom, $urandom});
      else if ($urandom_range(0, 31) == 0)
        step(d, 1'b1, 64'd0);
      else
        step(d, 1'b0, {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
